// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared types and helpers for the parametrised data memory.
//   state_t     : controller states (ST_INIT zero-fill sweep, ST_READY serving)
//   RD_LAT_MAX  : largest supported read latency
//   merge_byte  : byte-enable merge of one byte lane
// -----------------------------------------------------------------------------
package data_mem_pkg;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  localparam int RD_LAT_MAX = 4;

  // One byte lane of a byte-enabled store: take the new byte when enabled.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       en);
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/data_memory_param_if.sv
// -----------------------------------------------------------------------------
// data_memory_param_if
// Request/response bus between the datapath (master) and the data memory
// (slave).
//   d_mem_req/we/addr/be/data_in : request, driven by the master
//   d_mem_ready                  : memory accepts a request this cycle
//   d_mem_rvalid/data_out        : load response
//   d_mem_err                    : out-of-range access pulse
// -----------------------------------------------------------------------------
interface data_memory_param_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6
);

  logic                  d_mem_req;
  logic                  d_mem_we;
  logic [ADDR_W-1:0]     d_mem_addr;
  logic [DATA_W/8-1:0]   d_mem_be;
  logic [DATA_W-1:0]     d_mem_data_in;
  logic                  d_mem_ready;
  logic                  d_mem_rvalid;
  logic [DATA_W-1:0]     d_mem_data_out;
  logic                  d_mem_err;

  modport master (
    output d_mem_req, d_mem_we, d_mem_addr, d_mem_be, d_mem_data_in,
    input  d_mem_ready, d_mem_rvalid, d_mem_data_out, d_mem_err
  );

  modport slave (
    input  d_mem_req, d_mem_we, d_mem_addr, d_mem_be, d_mem_data_in,
    output d_mem_ready, d_mem_rvalid, d_mem_data_out, d_mem_err
  );

endinterface

// File: rtl/data_mem_rd_pipe.sv
// -----------------------------------------------------------------------------
// data_mem_rd_pipe
// RD_LAT-stage shift register carrying {valid, err, data} for loads.
// Data of a stage only moves when a valid entry moves into it, so the last
// stage holds the most recent load result between responses.
//   clk, rst           : clock, synchronous active-high flush
//   in_valid/err/data  : load sampled at the accept edge
//   out_valid/err/data : response after RD_LAT cycles
// -----------------------------------------------------------------------------
module data_mem_rd_pipe
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("data_mem_rd_pipe: RD_LAT outside 1..RD_LAT_MAX");
  end

  logic [RD_LAT-1:0] vld;
  logic [RD_LAT-1:0] err;
  logic [DATA_W-1:0] dat [RD_LAT];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      err <= '0;
      for (int i = 0; i < RD_LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      err[0] <= in_valid & in_err;
      if (in_valid) dat[0] <= in_data;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        err[i] <= err[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_err   = err[RD_LAT-1];
  assign out_data  = dat[RD_LAT-1];

endmodule

// File: rtl/data_memory_param.sv
// -----------------------------------------------------------------------------
// data_memory_param
// Parametrised single-port data memory with a zero-fill sequencer after reset,
// byte-enabled stores, pipelined loads of latency RD_LAT and out-of-range
// error pulses.
//   clk        : clock, rising edge
//   rst        : synchronous reset, active-high
//   bus        : request/response interface (slave side)
//   init_busy  : zero-fill sweep in progress
// -----------------------------------------------------------------------------
module data_memory_param
  import data_mem_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 6,
  parameter int DEPTH        = 64,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  data_memory_param_if.slave   bus,
  output logic                 init_busy
);

  localparam int              NBYTES  = DATA_W / 8;
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt;
  logic              ready_int;
  logic              clear_en;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word;
  logic              st_err_q;

  logic              pipe_valid;
  logic              pipe_err;
  logic [DATA_W-1:0] pipe_data;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_ON_RST != 0) ? ST_INIT : ST_READY;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) cnt <= cnt + 1'b1;
    end
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:  if (cnt == LAST) state_next = ST_READY;
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_INIT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // rst gates the outputs directly so they read as reset values during the
  // whole reset cycle, not only after the first reset edge.
  always_comb begin
    ready_int = 1'b0;
    clear_en  = 1'b0;
    init_busy = (CLEAR_ON_RST != 0);
    if (!rst) begin
      ready_int = (state == ST_READY);
      clear_en  = (state == ST_INIT);
      init_busy = (state == ST_INIT);
    end
  end

  // ---------------- Access decode ----------------
  assign accept   = bus.d_mem_req & ready_int;
  assign in_range = {1'b0, bus.d_mem_addr} < DEPTH_W;
  assign rd_word  = in_range ? mem[bus.d_mem_addr] : '0;

  always_comb begin
    wr_word = rd_word;
    for (int i = 0; i < NBYTES; i++) begin
      wr_word[8*i +: 8] = merge_byte(rd_word[8*i +: 8],
                                     bus.d_mem_data_in[8*i +: 8],
                                     bus.d_mem_be[i]);
    end
  end

  // ---------------- Storage ----------------
  // NOTE: the array itself has no reset; the INIT sweep zero-fills it one word
  // per cycle, which keeps it mappable onto a plain RAM.
  always_ff @(posedge clk) begin
    if (clear_en) begin
      mem[cnt] <= '0;
    end else if (accept && bus.d_mem_we && in_range) begin
      mem[bus.d_mem_addr] <= wr_word;
    end
  end

  // Out-of-range stores are dropped and flagged in the cycle after accept.
  always_ff @(posedge clk) begin
    if (rst) st_err_q <= 1'b0;
    else     st_err_q <= accept & bus.d_mem_we & ~in_range;
  end

  // ---------------- Load pipeline ----------------
  data_mem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept & ~bus.d_mem_we),
    .in_err    (~in_range),
    .in_data   (rd_word),
    .out_valid (pipe_valid),
    .out_err   (pipe_err),
    .out_data  (pipe_data)
  );

  assign bus.d_mem_ready    = ready_int;
  assign bus.d_mem_rvalid   = pipe_valid & ~rst;
  assign bus.d_mem_data_out = rst ? '0 : pipe_data;
  assign bus.d_mem_err      = (st_err_q | pipe_err) & ~rst;

endmodule

// File: tb/tb_data_memory_param.sv
// -----------------------------------------------------------------------------
// tb_data_memory_param
// Self-checking bench for data_memory_param (DATA_W=64, ADDR_W=6, DEPTH=48,
// RD_LAT=2, CLEAR_ON_RST=1). A behavioural model (word array, countdown of
// remaining clear cycles, queue of pending load responses) predicts every
// output each cycle; directed sequences are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_data_memory_param;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 48;
  localparam int RD_LAT = 2;

  typedef struct {
    int          due;
    logic [63:0] data;
    bit          err;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  logic init_busy;

  data_memory_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  data_memory_param #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .DEPTH        (DEPTH),
    .RD_LAT       (RD_LAT),
    .CLEAR_ON_RST (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  // ---------------- Reference model state ----------------
  logic [63:0] model_mem [DEPTH];
  int          init_left;
  resp_t       pend[$];
  int          st_err_due;
  logic [63:0] last_data;
  int          cyc;

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one cycle of inputs, advance the model at the rising edge, then
  // compare every output against the model on the falling edge.
  task automatic cycle(input bit r, input bit req, input bit we,
                       input logic [5:0] addr, input logic [7:0] be,
                       input logic [63:0] din);
    resp_t e;
    bit    exp_v;
    bit    exp_err;

    rst                = r;
    bus.d_mem_req      = req;
    bus.d_mem_we       = we;
    bus.d_mem_addr     = addr;
    bus.d_mem_be       = be;
    bus.d_mem_data_in  = din;

    @(posedge clk);
    cyc++;
    if (r) begin
      init_left  = DEPTH;
      pend.delete();
      st_err_due = -1;
      last_data  = '0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else if (init_left > 0) begin
      init_left--;
    end else if (req) begin
      if (int'(addr) >= DEPTH) begin
        if (we) st_err_due = cyc;
        else    pend.push_back('{due: cyc + RD_LAT - 1, data: 64'd0, err: 1'b1});
      end else if (we) begin
        for (int b = 0; b < 8; b++)
          if (be[b]) model_mem[addr][8*b +: 8] = din[8*b +: 8];
      end else begin
        pend.push_back('{due: cyc + RD_LAT - 1, data: model_mem[addr], err: 1'b0});
      end
    end

    @(negedge clk);
    exp_v   = 1'b0;
    exp_err = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e         = pend.pop_front();
      exp_v     = 1'b1;
      exp_err   = e.err;
      last_data = e.data;
    end
    if (st_err_due == cyc) exp_err = 1'b1;

    check($sformatf("ready@%0d", cyc), 64'(bus.d_mem_ready),
          64'(!r && init_left == 0));
    check($sformatf("init_busy@%0d", cyc), 64'(init_busy),
          64'(r || init_left > 0));
    check($sformatf("rvalid@%0d", cyc), 64'(bus.d_mem_rvalid), 64'(exp_v));
    check($sformatf("err@%0d", cyc), 64'(bus.d_mem_err), 64'(exp_err));
    check($sformatf("data_out@%0d", cyc), bus.d_mem_data_out, last_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 64'd0);
  endtask

  task automatic load(input logic [5:0] a);
    cycle(1'b0, 1'b1, 1'b0, a, 8'h00, 64'd0);
  endtask

  task automatic store(input logic [5:0] a, input logic [63:0] d,
                       input logic [7:0] be);
    cycle(1'b0, 1'b1, 1'b1, a, be, d);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 6'd0, 8'h00, 64'd0);
  endtask

  initial begin
    bit          r;
    bit          req;
    bit          we;
    logic [5:0]  a;
    logic [7:0]  be;
    logic [63:0] d;

    n_checks   = 0;
    n_pass     = 0;
    cyc        = 0;
    init_left  = DEPTH;
    st_err_due = -1;
    last_data  = '0;

    // 1: reset, 48-cycle clear, then a load of a cleared word.
    reset_cycles(3);
    idle(DEPTH);
    load(6'd17);
    idle(3);

    // 2: two stores, then back-to-back loads.
    store(6'd1, 64'd5, 8'hFF);
    store(6'd2, 64'd17, 8'hFF);
    load(6'd1);
    load(6'd2);
    idle(3);

    // 3: byte-enable merge.
    store(6'd5, 64'h8000_0000_0000_0000, 8'hFF);
    store(6'd5, 64'h0000_0000_0000_00FF, 8'h01);
    load(6'd5);
    idle(3);

    // 4: out-of-range load and store; last in-range word untouched.
    load(6'd50);
    idle(3);
    store(6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    idle(1);
    load(6'd47);
    idle(3);

    // 5: reset while a load is in flight, then clear reruns.
    store(6'd3, 64'h1234, 8'hFF);
    load(6'd3);
    reset_cycles(1);
    idle(DEPTH);
    load(6'd3);
    idle(3);

    // 6: read-after-write in the very next cycle.
    store(6'd9, 64'hDEAD, 8'hFF);
    load(6'd9);
    idle(3);

    // Random traffic, with occasional resets and zero byte-enable stores.
    for (int i = 0; i < 700; i++) begin
      r   = ($urandom_range(0, 249) == 0);
      req = ($urandom_range(0, 3) != 0);
      we  = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 4) == 0) a = 6'($urandom_range(0, 63));
      else                           a = 6'($urandom_range(0, 11));
      be  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      d   = {$urandom, $urandom};
      cycle(r, req, we, a, be, d);
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
